microcode_sequencer: RTL and testbench
======================================

Name: microcode_sequencer

Overview:
Parametrised multi-cycle control unit that replaces the fixed single-cycle opcode-to-control-word decode. It holds a writable microcode store indexed by {opcode, step}. For each accepted opcode it emits one or more control words, one per cycle, and honours a downstream stall. It sits between fetch/issue and the datapath. The store is programmed at boot or by debug through a write port.

Parameters:
OP_W, 3, opcode width; 2**OP_W opcodes.
CW_W, 12, control word width.
STEPS, 4, max micro-steps per opcode; power of two, >= 2.
STEP_W, $clog2(STEPS), step index width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
op_valid  in  1  opcode offered by issue
op_ready  out  1  sequencer accepts opcode this cycle
opcode  in  OP_W  opcode, sampled on op_valid & op_ready
cw_valid  out  1  cw is a live control word
cw  out  CW_W  control word; forced 0 when cw_valid=0
cw_last  out  1  current word is final step of the opcode
cw_step  out  STEP_W  current step index
stall  in  1  datapath hold; current word repeats
flush  in  1  synchronous abort of current sequence
wr_en  in  1  microcode store write
wr_addr  in  OP_W+STEP_W  store address {opcode, step}
wr_data  in  CW_W+1  {last_bit, control_word}
busy  out  1  sequence in progress (state RUN)

Behaviour:
- Store: 2**OP_W * STEPS entries of CW_W+1 bits. Read is combinational from the registered {cur_op, step}. Write is synchronous on wr_en.
- Async rst: every store entry becomes {last=1, cw=0}, so an unprogrammed opcode is a one-cycle NOP. State = IDLE, step = 0, cur_op = 0.
- Outputs during reset and in IDLE: cw_valid=0, cw=0, cw_last=0, cw_step=0, busy=0, op_ready=1.
- States: IDLE and RUN.
- Transitions out of IDLE:
  - op_valid=1 (op_ready=1): latch cur_op=opcode, set step=0, go to RUN.
- In RUN:
  - Outputs: cw_valid=1, busy=1, cw and cw_last come from store[{cur_op, step}], cw_step=step.
  - Effective last (eff_last) = entry last bit OR step==STEPS-1. This caps the sequence even if the last bit was never set. cw_last reflects eff_last.
  - stall=1: step, cur_op and state hold, and cw is re-read each cycle.
  - stall=0 and eff_last=0: step increments by 1.
  - stall=0 and eff_last=1 and op_valid=0: go to IDLE.
  - stall=0 and eff_last=1 and op_valid=1: back-to-back. Latch the new opcode, set step=0, stay in RUN. There is no bubble.
- op_ready = (state==IDLE) | (state==RUN & eff_last & ~stall), then gated low by flush.
- Latency: opcode accepted at edge N gives step-0 word valid in cycle N+1.
- flush (highest priority after rst):
  - Next state = IDLE and step = 0.
  - op_ready=0 in the flush cycle, so no opcode is accepted.
  - cw_valid stays as computed in the flush cycle and drops on the following cycle.
- Write/read collision: a write to the entry currently being read shows the old value in that cycle and the new value from the next cycle. Writes are allowed in any state.
- Reset mid-sequence: immediate return to the reset values above. Store contents are re-cleared.
- No illegal addresses exist; all wr_addr values map to entries.

Test Plan:
- Reset, no programming: op_valid=1, opcode=3 -> op_ready=1; next cycle cw_valid=1, cw=0, cw_last=1, cw_step=0; following cycle IDLE.
- Program op 5: steps 0..2 = 0x111, 0x222, {last=1, 0x333}; issue 5 -> cw=0x111, 0x222, 0x333 on 3 consecutive cycles, cw_last only on the third; busy high for exactly 3 cycles.
- Stall: same op 5, stall=1 for 2 cycles while step=1 -> cw=0x222 held 3 cycles total, then 0x333; op_ready=0 throughout the stall.
- Back-to-back: op 5 followed by op 5 held valid -> op_ready=1 in the 0x333 cycle; next cycle cw=0x111, step=0, with no idle gap.
- Cap: op 2 programmed with all last bits 0 (STEPS=4) -> 4 words, cw_last=1 at cw_step=3, then IDLE.
- Flush at step=1 of op 5 -> op_ready=0 in that cycle; next cycle cw_valid=0, busy=0, cw=0; reissue restarts at step 0.
- Write collision: during op 5 step 1, write {0, 0xABC} to address {5, 1} with stall=1 -> cw=0x222 in the write cycle, 0xABC from the next cycle.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Multi-cycle microcoded control unit: a writable store indexed by {opcode, step}
// emits one control word per cycle for each accepted opcode, honouring stall and flush.
module microcode_sequencer #(
    parameter int unsigned OP_W  = 3,
    parameter int unsigned CW_W  = 12,
    parameter int unsigned STEPS = 4,
    localparam int unsigned STEP_W = $clog2(STEPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [OP_W-1:0]        opcode,
    output logic                   cw_valid,
    output logic [CW_W-1:0]        cw,
    output logic                   cw_last,
    output logic [STEP_W-1:0]      cw_step,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [OP_W+STEP_W-1:0] wr_addr,
    input  logic [CW_W:0]          wr_data,
    output logic                   busy
);

    localparam int unsigned ADDR_W = OP_W + STEP_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [OP_W-1:0]     r_cur_op;
    logic [OP_W-1:0]     w_cur_op_nxt;
    logic [CW_W:0]       r_store [DEPTH];
    logic [CW_W:0]       w_rd;
    logic                w_eff_last;

    // Store: reset makes every opcode a single-cycle NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_store[i] <= {1'b1, CW_W'(0)};
            end
        end else if (wr_en) begin
            r_store[wr_addr] <= wr_data;
        end
    end

    assign w_rd       = r_store[{r_cur_op, r_step}];
    assign w_eff_last = w_rd[CW_W] | (r_step == STEP_W'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_cur_op <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_cur_op <= w_cur_op_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_cur_op_nxt = r_cur_op;
        op_ready     = 1'b0;
        cw_valid     = 1'b0;
        cw           = '0;
        cw_last      = 1'b0;
        cw_step      = '0;
        busy         = 1'b0;

        case (r_state)
            S_IDLE: begin
                op_ready = ~flush;
                if (flush) begin
                    w_step_nxt = '0;
                end else if (op_valid) begin
                    w_state_nxt  = S_RUN;
                    w_cur_op_nxt = opcode;
                    w_step_nxt   = '0;
                end
            end
            S_RUN: begin
                cw_valid = 1'b1;
                busy     = 1'b1;
                cw       = w_rd[CW_W-1:0];
                cw_last  = w_eff_last;
                cw_step  = r_step;
                op_ready = w_eff_last & ~stall & ~flush;
                // Flush overrides stall; back-to-back accept reuses RUN with no bubble
                if (flush) begin
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                end else if (!stall) begin
                    if (!w_eff_last) begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end else if (op_valid) begin
                        w_cur_op_nxt = opcode;
                        w_step_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_step_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed self-checking bench for microcode_sequencer: programming, sequencing,
// stall, back-to-back issue, step cap, flush, write collision and mid-sequence reset.
module tb_microcode_sequencer;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned CW_W   = 12;
    localparam int unsigned STEPS  = 4;
    localparam int unsigned STEP_W = 2;

    logic              clk;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   opcode;
    logic              cw_valid;
    logic [CW_W-1:0]   cw;
    logic              cw_last;
    logic [STEP_W-1:0] cw_step;
    logic              stall;
    logic              flush;
    logic              wr_en;
    logic [OP_W+STEP_W-1:0] wr_addr;
    logic [CW_W:0]     wr_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    microcode_sequencer #(
        .OP_W  (OP_W),
        .CW_W  (CW_W),
        .STEPS (STEPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .opcode   (opcode),
        .cw_valid (cw_valid),
        .cw       (cw),
        .cw_last  (cw_last),
        .cw_step  (cw_step),
        .stall    (stall),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Compare {valid, last, busy, ready, step, cw} 1 time unit after inputs settle
    task automatic chk(input string tag, input logic ev, input logic [CW_W-1:0] ecw,
                       input logic el, input logic [STEP_W-1:0] es,
                       input logic eb, input logic er);
        logic [17:0] obs;
        logic [17:0] exp;
        #1;
        obs = {cw_valid, cw_last, busy, op_ready, cw_step, cw};
        exp = {ev, el, eb, er, es, ecw};
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed={v%b l%b b%b r%b s%0d cw%h} expected={v%b l%b b%b r%b s%0d cw%h}",
                   tag, obs[17], obs[16], obs[15], obs[14], obs[13:12], obs[11:0],
                   exp[17], exp[16], exp[15], exp[14], exp[13:12], exp[11:0]);
        end
    endtask

    task automatic wr(input logic [OP_W-1:0] op, input logic [STEP_W-1:0] st,
                      input logic lst, input logic [CW_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = {op, st};
        wr_data = {lst, d};
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; opcode = '0; stall = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #2;
        chk("reset", 0, 12'h000, 0, 0, 0, 1);
        tick();
        tick();
        rst = 1'b0;

        // Unprogrammed opcode is a one-cycle NOP
        op_valid = 1'b1; opcode = 3'd3;
        chk("nop_idle", 0, 12'h000, 0, 0, 0, 1);
        tick(); op_valid = 1'b0;
        chk("nop_run", 1, 12'h000, 1, 0, 1, 1);
        tick();
        chk("nop_done", 0, 12'h000, 0, 0, 0, 1);

        // Program op 5 (3 steps) and op 2 (no last bits)
        wr(3'd5, 2'd0, 1'b0, 12'h111);
        wr(3'd5, 2'd1, 1'b0, 12'h222);
        wr(3'd5, 2'd2, 1'b1, 12'h333);
        wr(3'd2, 2'd0, 1'b0, 12'h201);
        wr(3'd2, 2'd1, 1'b0, 12'h202);
        wr(3'd2, 2'd2, 1'b0, 12'h203);
        wr(3'd2, 2'd3, 1'b0, 12'h204);

        // Basic op 5 sequence
        op_valid = 1'b1; opcode = 3'd5;
        chk("seq_idle", 0, 12'h000, 0, 0, 0, 1);
        tick(); op_valid = 1'b0;
        chk("seq_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); chk("seq_s1", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("seq_s2", 1, 12'h333, 1, 2, 1, 1);
        tick(); chk("seq_end", 0, 12'h000, 0, 0, 0, 1);

        // Stall two cycles at step 1
        op_valid = 1'b1; opcode = 3'd5;
        tick(); op_valid = 1'b0;
        chk("stl_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); stall = 1'b1;
        chk("stl_a", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("stl_b", 1, 12'h222, 0, 1, 1, 0);
        tick(); stall = 1'b0;
        chk("stl_c", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("stl_s2", 1, 12'h333, 1, 2, 1, 1);
        tick(); chk("stl_end", 0, 12'h000, 0, 0, 0, 1);

        // Stall on the last step blocks acceptance
        op_valid = 1'b1; opcode = 3'd3;
        tick(); stall = 1'b1;
        chk("stl_last", 1, 12'h000, 1, 0, 1, 0);
        tick(); stall = 1'b0; op_valid = 1'b0;
        chk("stl_last_rel", 1, 12'h000, 1, 0, 1, 1);
        tick();

        // Back-to-back op 5 with op_valid held
        op_valid = 1'b1; opcode = 3'd5;
        tick(); chk("b2b_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); chk("b2b_s1", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("b2b_s2", 1, 12'h333, 1, 2, 1, 1);
        tick(); op_valid = 1'b0;
        chk("b2b_again_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); chk("b2b_again_s1", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("b2b_again_s2", 1, 12'h333, 1, 2, 1, 1);
        tick(); chk("b2b_end", 0, 12'h000, 0, 0, 0, 1);

        // Step cap on op 2
        op_valid = 1'b1; opcode = 3'd2;
        tick(); op_valid = 1'b0;
        chk("cap_s0", 1, 12'h201, 0, 0, 1, 0);
        tick(); chk("cap_s1", 1, 12'h202, 0, 1, 1, 0);
        tick(); chk("cap_s2", 1, 12'h203, 0, 2, 1, 0);
        tick(); chk("cap_s3", 1, 12'h204, 1, 3, 1, 1);
        tick(); chk("cap_end", 0, 12'h000, 0, 0, 0, 1);

        // Flush at step 1, then reissue
        op_valid = 1'b1; opcode = 3'd5;
        tick(); op_valid = 1'b0;
        chk("fl_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); flush = 1'b1; op_valid = 1'b1;
        chk("fl_cycle", 1, 12'h222, 0, 1, 1, 0);
        tick(); flush = 1'b0; op_valid = 1'b0;
        chk("fl_after", 0, 12'h000, 0, 0, 0, 1);
        flush = 1'b1; op_valid = 1'b1;
        chk("fl_idle_gate", 0, 12'h000, 0, 0, 0, 0);
        tick(); flush = 1'b0;
        chk("fl_idle_hold", 0, 12'h000, 0, 0, 0, 1);
        tick(); op_valid = 1'b0;
        chk("fl_re_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); chk("fl_re_s1", 1, 12'h222, 0, 1, 1, 0);
        tick(); chk("fl_re_s2", 1, 12'h333, 1, 2, 1, 1);
        tick();

        // Write collision on the entry being read
        op_valid = 1'b1; opcode = 3'd5;
        tick(); op_valid = 1'b0;
        chk("col_s0", 1, 12'h111, 0, 0, 1, 0);
        tick(); stall = 1'b1; wr_en = 1'b1; wr_addr = {3'd5, 2'd1}; wr_data = {1'b0, 12'hABC};
        chk("col_write", 1, 12'h222, 0, 1, 1, 0);
        tick(); wr_en = 1'b0;
        chk("col_new", 1, 12'hABC, 0, 1, 1, 0);
        tick(); stall = 1'b0;
        chk("col_rel", 1, 12'hABC, 0, 1, 1, 0);
        tick(); chk("col_s2", 1, 12'h333, 1, 2, 1, 1);
        tick(); chk("col_end", 0, 12'h000, 0, 0, 0, 1);

        // Reset mid-sequence clears state and store
        op_valid = 1'b1; opcode = 3'd5;
        tick(); op_valid = 1'b0;
        chk("rst_pre", 1, 12'h111, 0, 0, 1, 0);
        rst = 1'b1;
        chk("rst_mid", 0, 12'h000, 0, 0, 0, 1);
        rst = 1'b0;
        op_valid = 1'b1; opcode = 3'd5;
        chk("rst_idle", 0, 12'h000, 0, 0, 0, 1);
        tick(); op_valid = 1'b0;
        chk("rst_cleared", 1, 12'h000, 1, 0, 1, 1);
        tick(); chk("rst_end", 0, 12'h000, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
